// File: rtl/branch_pkg.sv
// Shared types for the branch sequencer: opcode encoding, FSM states, stat width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package branch_pkg;

  // Condition codes as seen on req_op; code 7 is reserved and treated as illegal.
  typedef enum logic [2:0] {
    BEQ    = 3'd0,
    BNE    = 3'd1,
    BLT    = 3'd2,
    BGT    = 3'd3,
    BLE    = 3'd4,
    BGE    = 3'd5,
    JMP    = 3'd6,
    OP_ILL = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMPARE  = 2'd1,
    RESOLVE  = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  // Width of the optional taken/not-taken statistics counters.
  localparam int STAT_W = 16;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: maps (op, lt, eq, gt) to (taken, err).
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module branch_cond
  import branch_pkg::*;
(
  input  op_t  op,
  input  logic lt,
  input  logic eq,
  input  logic gt,
  output logic taken,
  output logic err
);

  logic flags_ok;
  logic cond;
  logic op_bad;

  // Exactly one flag must be set; an illegal flag set or opcode kills the branch.
  always_comb begin
    flags_ok = (lt ^ eq ^ gt) & ~(lt & eq & gt);
    cond     = 1'b0;
    op_bad   = 1'b0;
    case (op)
      BEQ:     cond = eq;
      BNE:     cond = ~eq;
      BLT:     cond = lt;
      BGT:     cond = gt;
      BLE:     cond = lt | eq;
      BGE:     cond = gt | eq;
      JMP:     cond = 1'b1;
      default: op_bad = 1'b1;
    endcase
    taken = cond & flags_ok & ~op_bad;
    err   = ~flags_ok | op_bad;
  end

endmodule

// File: rtl/branch_sequencer.sv
// Branch sequencer: drives the shared comparator, resolves the condition, issues PC redirects.
// Latency: accept to done is 3 cycles not-taken, 4 cycles taken with redir_ready already high.
// Backpressure: req_ready low while busy; redirect waits on redir_ready (optional BRANCH_STATS_EN counters).
module branch_sequencer
  import branch_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int OW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  input  logic [AW-1:0] req_pc,
  input  logic [OW-1:0] req_off,
  output logic [DW-1:0] cmp_a,
  output logic [DW-1:0] cmp_b,
  input  logic          cmp_lt,
  input  logic          cmp_eq,
  input  logic          cmp_gt,
  output logic          redir_valid,
  input  logic          redir_ready,
  output logic [AW-1:0] redir_pc,
  output logic          done,
  output logic          taken,
`ifdef BRANCH_STATS_EN
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_not_taken,
`endif
  output logic          err
);

  state_t        state;
  state_t        state_nxt;
  op_t           op_q;
  logic [AW-1:0] pc_q;
  logic [OW-1:0] off_q;
  logic          cond_taken;
  logic          cond_err;
  logic [AW-1:0] target;
  logic          fin_not_taken;
  logic          fin_taken;

  branch_cond u_cond (
    .op    (op_q),
    .lt    (cmp_lt),
    .eq    (cmp_eq),
    .gt    (cmp_gt),
    .taken (cond_taken),
    .err   (cond_err)
  );

  // Sign-extend the offset to PC width; the add wraps modulo 2^AW.
  assign target = pc_q + AW'($signed(off_q));

  assign fin_not_taken = (state == RESOLVE) && !cond_taken;
  assign fin_taken     = (state == REDIRECT) && redir_ready;

  // State register; reset abandons any branch in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic plus the req_ready / redir_valid state decodes.
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    redir_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = COMPARE;
      end
      COMPARE:  state_nxt = RESOLVE;
      RESOLVE:  state_nxt = cond_taken ? REDIRECT : IDLE;
      REDIRECT: begin
        redir_valid = 1'b1;
        if (redir_ready) state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // Request capture, target register and the registered done/taken/err pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= BEQ;
      pc_q     <= '0;
      off_q    <= '0;
      cmp_a    <= '0;
      cmp_b    <= '0;
      redir_pc <= '0;
      done     <= 1'b0;
      taken    <= 1'b0;
      err      <= 1'b0;
    end else begin
      done  <= 1'b0;
      taken <= 1'b0;
      err   <= 1'b0;
      // Operands go straight to the comparator and hold until the next accept.
      if (state == IDLE && req_valid) begin
        op_q  <= op_t'(req_op);
        pc_q  <= req_pc;
        off_q <= req_off;
        cmp_a <= req_a;
        cmp_b <= req_b;
      end
      if (state == RESOLVE) begin
        err <= cond_err;
        if (cond_taken) redir_pc <= target;
      end
      if (fin_not_taken) done <= 1'b1;
      if (fin_taken) begin
        done  <= 1'b1;
        taken <= 1'b1;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  // Saturating resolution counters, bumped on the edge that raises done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_taken     <= '0;
      stat_not_taken <= '0;
    end else begin
      if (fin_taken && stat_taken != {STAT_W{1'b1}})
        stat_taken <= stat_taken + 1'b1;
      if (fin_not_taken && stat_not_taken != {STAT_W{1'b1}})
        stat_not_taken <= stat_not_taken + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed cases then randomized branches vs a model.
// Latency: checks 3-cycle not-taken and (4 + stall)-cycle taken resolution.
// Backpressure: exercises held-low redir_ready and a reset during REDIRECT.
module tb_branch_sequencer;
  import branch_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int OW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic [AW-1:0] req_pc;
  logic [OW-1:0] req_off;
  logic [DW-1:0] cmp_a;
  logic [DW-1:0] cmp_b;
  logic          cmp_lt;
  logic          cmp_eq;
  logic          cmp_gt;
  logic          redir_valid;
  logic          redir_ready;
  logic [AW-1:0] redir_pc;
  logic          done;
  logic          taken;
  logic          err;
`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_taken;
  logic [STAT_W-1:0] stat_not_taken;
`endif

  // Comparator model, with an override to inject illegal flag combinations.
  logic force_flags = 1'b0;
  logic f_lt = 1'b0;
  logic f_eq = 1'b0;
  logic f_gt = 1'b0;
  assign cmp_lt = force_flags ? f_lt : (cmp_a < cmp_b);
  assign cmp_eq = force_flags ? f_eq : (cmp_a == cmp_b);
  assign cmp_gt = force_flags ? f_gt : (cmp_a > cmp_b);

  always #5 clk = ~clk;

  branch_sequencer #(.DW(DW), .AW(AW), .OW(OW)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_pc         (req_pc),
    .req_off        (req_off),
    .cmp_a          (cmp_a),
    .cmp_b          (cmp_b),
    .cmp_lt         (cmp_lt),
    .cmp_eq         (cmp_eq),
    .cmp_gt         (cmp_gt),
    .redir_valid    (redir_valid),
    .redir_ready    (redir_ready),
    .redir_pc       (redir_pc),
    .done           (done),
    .taken          (taken),
`ifdef BRANCH_STATS_EN
    .stat_taken     (stat_taken),
    .stat_not_taken (stat_not_taken),
`endif
    .err            (err)
  );

  int n_pass  = 0;
  int n_total = 0;
  int exp_tk_cnt = 0;
  int exp_nt_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: branch outcome and target straight from the condition rules.
  function automatic void model(input int op, input int a, input int b, input bit frc,
                                input bit flt, input bit feq, input bit fgt,
                                input int pc, input int off,
                                output bit tk, output bit er, output int tgt);
    int lt, eq, gt, so;
    bit legal, c;
    if (frc) begin lt = flt; eq = feq; gt = fgt; end
    else begin lt = int'(a < b); eq = int'(a == b); gt = int'(a > b); end
    legal = (lt + eq + gt) == 1;
    case (op)
      0: c = eq != 0;
      1: c = eq == 0;
      2: c = lt != 0;
      3: c = gt != 0;
      4: c = (lt + eq) != 0;
      5: c = (gt + eq) != 0;
      6: c = 1'b1;
      default: c = 1'b0;
    endcase
    tk  = legal && op != 7 && c;
    er  = !legal || op == 7;
    so  = (off >= (1 << (OW - 1))) ? off - (1 << OW) : off;
    tgt = (pc + so + (1 << AW)) % (1 << AW);
  endfunction

  // One request from presentation to done; d = valid cycles with redir_ready held low.
  task automatic run_branch(input string tag, input int op, input int a, input int b,
                            input int pc, input int off, input int d, input bit frc,
                            input bit flt, input bit feq, input bit fgt);
    bit tk, er, saw_v, got;
    int tgt, cnt, stall;
    model(op, a, b, frc, flt, feq, fgt, pc, off, tk, er, tgt);
    force_flags = frc; f_lt = flt; f_eq = feq; f_gt = fgt;
    check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_op      = op[2:0];
    req_a       = a[DW-1:0];
    req_b       = b[DW-1:0];
    req_pc      = pc[AW-1:0];
    req_off     = off[OW-1:0];
    redir_ready = (d == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, " cmp_a"}, 32'(cmp_a), a);
    check({tag, " cmp_b"}, 32'(cmp_b), b);
    cnt = 0; stall = 0; saw_v = 1'b0; got = 1'b0;
    while (!got && cnt < 60) begin
      if (done) got = 1'b1;
      else begin
        if (redir_valid) begin
          saw_v = 1'b1;
          check({tag, " redir_pc"}, 32'(redir_pc), tgt);
          check({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
          if (stall == d) redir_ready = 1'b1;
          else stall++;
        end
        @(posedge clk); #1;
        cnt++;
      end
    end
    check({tag, " done seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, cnt, tk ? 3 + d : 2);
    check({tag, " taken"}, 32'(taken), 32'(tk));
    check({tag, " err"}, 32'(err), 32'(er));
    check({tag, " redir seen"}, 32'(saw_v), 32'(tk));
    if (got) begin
      if (tk) exp_tk_cnt++;
      else    exp_nt_cnt++;
    end
    force_flags = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    @(posedge clk); #1;
    check({tag, " done pulse"}, 32'(done), 32'd0);
    check({tag, " err pulse"}, 32'(err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    req_pc = '0; req_off = '0; redir_ready = 1'b0;
    #12;
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst redir_valid", 32'(redir_valid), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst taken", 32'(taken), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst redir_pc", 32'(redir_pc), 32'd0);
    check("rst cmp_a", 32'(cmp_a), 32'd0);
    check("rst cmp_b", 32'(cmp_b), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_branch("beq_nt", 0, 5, 3, 8'h40, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_quiet("beq_nt");
    run_branch("ble_eq", 4, 9, 9, 8'h10, 6'h3C, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_quiet("ble_eq");
    run_branch("jmp_wrap", 6, 1, 2, 8'hFE, 3, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    run_branch("bad_flags", 0, 4, 4, 8'h20, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_quiet("bad_flags");
    run_branch("bad_op", 7, 4, 4, 8'h20, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_quiet("bad_op");

    // Reset while a redirect is pending.
    redir_ready = 1'b0;
    req_valid = 1'b1; req_op = 3'd6; req_pc = 8'h20; req_off = 6'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    waited = 0;
    while (!redir_valid && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    check("rstmid redir seen", 32'(redir_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rstmid redir_valid", 32'(redir_valid), 32'd0);
    check("rstmid req_ready", 32'(req_ready), 32'd1);
    check("rstmid done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_tk_cnt = 0; exp_nt_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstmid no done", 32'(done), 32'd0);
      check("rstmid idle", 32'(req_ready), 32'd1);
    end

    // Back-to-back: each request presented on the previous done cycle.
    run_branch("b2b0", 6, 1, 1, 8'h30, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_branch("b2b1", 2, 1, 7, 8'h31, 6'h3F, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_branch("b2b2", 1, 3, 3, 8'h32, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_branch("b2b3", 5, 9, 2, 8'h33, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_branch("b2b4", 3, 2, 9, 8'h34, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef BRANCH_STATS_EN
    check("stat_taken 3", 32'(stat_taken), 32'd3);
    check("stat_not_taken 2", 32'(stat_not_taken), 32'd2);
`endif

    for (int i = 0; i < 24; i++) begin
      int op, a, b, pc, off, d;
      bit frc;
      logic [2:0] fl;
      op  = $urandom_range(0, 7);
      a   = $urandom_range(0, 255);
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 255);
      pc  = $urandom_range(0, 255);
      off = $urandom_range(0, 63);
      d   = $urandom_range(0, 3);
      frc = ($urandom_range(0, 7) == 0);
      fl  = 3'($urandom_range(0, 7));
      run_branch("rand", op, a, b, pc, off, d, frc, fl[0], fl[1], fl[2]);
    end
    check_quiet("rand end");
`ifdef BRANCH_STATS_EN
    check("stat_taken final", 32'(stat_taken), exp_tk_cnt);
    check("stat_not_taken final", 32'(stat_not_taken), exp_nt_cnt);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
